ixu_execute: RTL and testbench
==============================

IXU_EXECUTE -- requirements
Module: ixu_execute

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream decoded instruction present.
REQ-005 SHALL have port in_ready  output  1  stage can accept an instruction this cycle.
REQ-006 SHALL have port in_op  input  4  ALU op: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu.
REQ-007 SHALL have port in_is_nop  input  1  instruction is NOP.
REQ-008 SHALL have port in_is_imm_type  input  1  operand B is the immediate.
REQ-009 SHALL have ports in_rs1_val, in_rs2_val  input  XLEN  register operand values.
REQ-010 SHALL have port in_imm  input  12  raw immediate.
REQ-011 SHALL have port in_rd  input  5  destination register.
REQ-012 SHALL have port flush  input  1  discard all held instructions.
REQ-013 SHALL have port out_valid  output  1  writeback record present.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the record.
REQ-015 SHALL have ports out_rd (5), out_result (XLEN), out_we (1)  output  writeback destination, value, write enable.
REQ-016 SHALL have port illegal_op  output  1  sticky flag, in_op above 9 accepted.
REQ-017 SHALL have port retire_cnt  output  32  count of records accepted downstream.

Function
REQ-018 SHALL be a two-entry elastic stage: main register plus skid register; latency in-accept to out_valid is exactly 1 cycle when empty.
REQ-019 SHALL accept an instruction when in_valid and in_ready are both high on a rising edge.
REQ-020 SHALL drive in_ready high iff skid register empty (registered, no combinational path from out_ready).
REQ-021 SHALL compute result at accept; operand B = sign-extended in_imm when in_is_imm_type, else in_rs2_val.
REQ-022 SHALL use B[4:0] as shift amount for ops 5-7; sra SHALL replicate bit XLEN-1.
REQ-023 SHALL produce slt/sltu results 1 or 0 (signed/unsigned compare), zero-extended.
REQ-024 SHALL wrap add/sub modulo 2^XLEN with no overflow indication.
REQ-025 SHALL set out_we = 0 when in_is_nop, in_rd == 0, or in_op > 9; otherwise 1.
REQ-026 SHALL propagate NOPs as records (out_valid high, out_we 0, out_result 0) to preserve slot ordering.
REQ-027 SHALL set illegal_op on accepting in_op > 9 with in_is_nop low; result 0; flag cleared only by reset.
REQ-028 SHALL hold out_* stable while out_valid high and out_ready low.
REQ-029 SHALL, when main is full, out_ready low and an accept occurs, place the new entry in the skid register; in_ready falls next cycle.
REQ-030 SHALL, when out_ready high with skid full, move skid to main in the same edge; order strictly FIFO.
REQ-031 SHALL handle simultaneous accept and drain: main takes the new entry, out_valid stays high, no bubble.
REQ-032 SHALL increment retire_cnt by 1 per out_valid&&out_ready, wrapping 0xFFFFFFFF to 0; NOP records counted.
REQ-033 SHALL, on flush, empty both entries at that edge and ignore any simultaneous accept; out_valid low next cycle; retire_cnt still counts a handshake on the flush edge.

Reset
REQ-034 SHALL, on rst_n low, asynchronously clear out_valid, both entry-valid bits, illegal_op, retire_cnt, out_rd, out_result, out_we to 0.
REQ-035 SHALL drive in_ready high from the first edge after rst_n deasserts; reset mid-transfer discards held entries.

Verification
REQ-036 addi: rs1=5, imm=0xFFF, imm type, rd=3, out_ready=1 -> next cycle out_valid=1, out_result=4, out_rd=3, out_we=1.
REQ-037 sra: rs1=0x80000000, rs2=0x24, op 7 -> out_result=0xF8000000 (shift 4 only).
REQ-038 Backpressure: out_ready=0, issue sub 10-3 then slt -1<1 -> in_ready low after second; raise out_ready -> results 7 then 1 in order, retire_cnt=2.
REQ-039 NOP and rd=0: add to rd=0, then NOP -> two records, out_we=0 both, illegal_op stays 0.
REQ-040 Illegal/flush: op=0xC accepted -> illegal_op=1 persists; flush with two entries held -> out_valid=0 next cycle, in_ready=1.
REQ-041 Async reset asserted mid-backpressure -> all outputs 0 immediately without a clock edge.

Source files
------------

// File: rtl/ixu_execute.sv
// ixu_execute: two-entry elastic ALU execute stage (main + skid register)
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          upstream handshake (in_ready = skid empty, registered)
//   in_op, in_is_nop, in_is_imm_type, in_rs1_val, in_rs2_val, in_imm, in_rd
//                              decoded instruction fields
//   flush                      drop both held entries
//   out_valid/out_ready        downstream handshake
//   out_rd, out_result, out_we writeback record
//   illegal_op                 sticky illegal-op flag
//   retire_cnt                 count of records accepted downstream
module ixu_execute #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic            in_is_nop,
    input  logic            in_is_imm_type,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [11:0]     in_imm,
    input  logic [4:0]      in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_result,
    output logic            out_we,
    output logic            illegal_op,
    output logic [31:0]     retire_cnt
);
    logic            r_main_v, r_skid_v, r_main_we, r_skid_we, r_ill;
    logic [4:0]      r_main_rd, r_skid_rd;
    logic [XLEN-1:0] r_main_res, r_skid_res;
    logic [31:0]     r_cnt;
    logic [XLEN-1:0] w_b, w_alu, w_res;
    logic [4:0]      w_sh;
    logic            w_illegal, w_we, w_acc, w_drn;

    assign w_b       = in_is_imm_type ? {{(XLEN-12){in_imm[11]}}, in_imm} : in_rs2_val;
    assign w_sh      = w_b[4:0];
    assign w_illegal = in_op > 4'd9;
    assign w_we      = !in_is_nop && (in_rd != 5'd0) && !w_illegal;
    assign w_acc     = in_valid && in_ready;
    assign w_drn     = r_main_v && out_ready;

    always_comb begin
        w_alu = '0;
        case (in_op)
            4'd0: w_alu = in_rs1_val + w_b;
            4'd1: w_alu = in_rs1_val - w_b;
            4'd2: w_alu = in_rs1_val ^ w_b;
            4'd3: w_alu = in_rs1_val | w_b;
            4'd4: w_alu = in_rs1_val & w_b;
            4'd5: w_alu = in_rs1_val << w_sh;
            4'd6: w_alu = in_rs1_val >> w_sh;
            4'd7: w_alu = $signed(in_rs1_val) >>> w_sh;
            4'd8: w_alu = {{(XLEN-1){1'b0}}, $signed(in_rs1_val) < $signed(w_b)};
            4'd9: w_alu = {{(XLEN-1){1'b0}}, in_rs1_val < w_b};
            default: w_alu = '0;
        endcase
    end

    // NOPs and illegal ops still occupy a slot but carry a zero result
    assign w_res = (in_is_nop || w_illegal) ? '0 : w_alu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_main_we  <= 1'b0;
            r_skid_we  <= 1'b0;
            r_main_rd  <= '0;
            r_skid_rd  <= '0;
            r_main_res <= '0;
            r_skid_res <= '0;
            r_ill      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_drn)
                r_cnt <= r_cnt + 32'd1;
            if (w_acc && w_illegal && !in_is_nop && !flush)
                r_ill <= 1'b1;
            if (flush) begin
                r_main_v <= 1'b0;
                r_skid_v <= 1'b0;
            end else if (w_drn || !r_main_v) begin
                // main is free this edge: older skid entry has priority over new input
                if (r_skid_v) begin
                    r_main_v   <= 1'b1;
                    r_main_rd  <= r_skid_rd;
                    r_main_res <= r_skid_res;
                    r_main_we  <= r_skid_we;
                    r_skid_v   <= 1'b0;
                end else begin
                    r_main_v <= w_acc;
                    if (w_acc) begin
                        r_main_rd  <= in_rd;
                        r_main_res <= w_res;
                        r_main_we  <= w_we;
                    end
                end
            end else if (w_acc) begin
                r_skid_v   <= 1'b1;
                r_skid_rd  <= in_rd;
                r_skid_res <= w_res;
                r_skid_we  <= w_we;
            end
        end
    end

    assign in_ready   = !r_skid_v;
    assign out_valid  = r_main_v;
    assign out_rd     = r_main_rd;
    assign out_result = r_main_res;
    assign out_we     = r_main_we;
    assign illegal_op = r_ill;
    assign retire_cnt = r_cnt;
endmodule

// File: tb/tb_ixu_execute.sv
// tb_ixu_execute: self-checking bench for ixu_execute against a queue-based reference model
module tb_ixu_execute;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_is_nop, in_is_imm_type, flush;
    logic [3:0]  in_op;
    logic [31:0] in_rs1_val, in_rs2_val, out_result, retire_cnt;
    logic [11:0] in_imm;
    logic [4:0]  in_rd, out_rd;
    logic        out_valid, out_ready, out_we, illegal_op;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        logic        we;
    } rec_t;

    rec_t        mq[$];
    logic [31:0] m_cnt;
    logic        m_ill;
    int          checks = 0;
    int          errors = 0;

    ixu_execute #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_is_nop(in_is_nop), .in_is_imm_type(in_is_imm_type),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_rd(in_rd),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_result(out_result), .out_we(out_we), .illegal_op(illegal_op), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] ones;
        sh = b[4:0];
        ones = 32'hFFFF_FFFF;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a ^ b;
            4'd3: return a | b;
            4'd4: return a & b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
            4'd8: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            4'd9: return {31'd0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [11:0] imm, input logic it, input logic [4:0] rd, input logic nop);
        in_valid = 1'b1; in_op = op; in_rs1_val = a; in_rs2_val = b;
        in_imm = imm; in_is_imm_type = it; in_rd = rd; in_is_nop = nop;
    endtask

    // advance one clock, updating the reference model from the inputs seen at the edge
    task automatic tick();
        rec_t r;
        logic acc, drn;
        logic [31:0] b;
        acc = in_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && out_ready;
        b = in_is_imm_type ? {{20{in_imm[11]}}, in_imm} : in_rs2_val;
        r.rd = in_rd;
        r.we = !in_is_nop && in_rd != 5'd0 && in_op <= 4'd9;
        r.res = (in_is_nop || in_op > 4'd9) ? 32'd0 : ref_alu(in_op, in_rs1_val, b);
        @(posedge clk);
        #1;
        if (drn) begin
            m_cnt = m_cnt + 32'd1;
            void'(mq.pop_front());
        end
        if (flush) mq.delete();
        else if (acc) begin
            mq.push_back(r);
            if (in_op > 4'd9 && !in_is_nop) m_ill = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_is_nop = 1'b0; in_is_imm_type = 1'b0;
        in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_rd = '0; flush = 1'b0; out_ready = 1'b0;
        mq.delete(); m_cnt = '0; m_ill = 1'b0;
        #23;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal_op); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_retire got %0d want 0", retire_cnt); end
        checks++; if ({out_rd, out_result, out_we} !== 38'd0) begin errors++; $display("FAIL reset_record got %h/%h/%b want 0", out_rd, out_result, out_we); end
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        issue(4'd0, 32'd5, 32'd0, 12'hFFF, 1'b1, 5'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid); end
        checks++; if ({out_rd, out_result, out_we} !== {5'd3, 32'd4, 1'b1}) begin errors++; $display("FAIL addi_record got rd=%0d res=%h we=%b want rd=3 res=4 we=1", out_rd, out_result, out_we); end
        tick();
    endtask

    task automatic test_sra();
        issue(4'd7, 32'h8000_0000, 32'h24, 12'd0, 1'b0, 5'd9, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (out_result !== 32'hF800_0000) begin errors++; $display("FAIL sra_result got %h want f8000000", out_result); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] base;
        base = m_cnt;
        checks++; if (retire_cnt !== base) begin errors++; $display("FAIL bp_base_retire got %0d want %0d", retire_cnt, base); end
        out_ready = 1'b0;
        issue(4'd1, 32'd10, 32'd3, 12'd0, 1'b0, 5'd1, 1'b0);
        tick();
        issue(4'd8, 32'hFFFF_FFFF, 32'd1, 12'd0, 1'b0, 5'd2, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        checks++; if (out_result !== 32'd7) begin errors++; $display("FAIL bp_first got %0d want 7", out_result); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd1 || out_rd !== 5'd2) begin errors++; $display("FAIL bp_second got v=%b res=%0d rd=%0d want v=1 res=1 rd=2", out_valid, out_result, out_rd); end
        tick();
        checks++; if (retire_cnt !== base + 32'd2 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_retire got cnt=%0d v=%b want cnt=%0d v=0", retire_cnt, out_valid, base + 32'd2); end
    endtask

    task automatic test_nop_rd0();
        out_ready = 1'b1;
        issue(4'd0, 32'd11, 32'd22, 12'd0, 1'b0, 5'd0, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_we !== 1'b0 || out_result !== 32'd33) begin errors++; $display("FAIL rd0_record got v=%b we=%b res=%0d want v=1 we=0 res=33", out_valid, out_we, out_result); end
        issue(4'd0, 32'd7, 32'd8, 12'd0, 1'b0, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_we !== 1'b0 || out_result !== 32'd0) begin errors++; $display("FAIL nop_record got v=%b we=%b res=%0d want v=1 we=0 res=0", out_valid, out_we, out_result); end
        checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL nop_illegal got %b want 0", illegal_op); end
        tick();
    endtask

    task automatic test_illegal_flush();
        out_ready = 1'b1;
        issue(4'hC, 32'd1, 32'd2, 12'd0, 1'b0, 5'd5, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (illegal_op !== 1'b1 || out_we !== 1'b0 || out_result !== 32'd0) begin errors++; $display("FAIL illegal_flag got ill=%b we=%b res=%h want 1/0/0", illegal_op, out_we, out_result); end
        tick();
        out_ready = 1'b0;
        issue(4'd2, 32'hF0, 32'h0F, 12'd0, 1'b0, 5'd6, 1'b0);
        tick();
        issue(4'd3, 32'h1, 32'h2, 12'd0, 1'b0, 5'd7, 1'b0);
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_full got rdy=%b v=%b want 0/1", in_ready, out_valid); end
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got v=%b rdy=%b want 0/1", out_valid, in_ready); end
        checks++; if (illegal_op !== 1'b1 || retire_cnt !== m_cnt) begin errors++; $display("FAIL flush_sticky got ill=%b cnt=%0d want 1/%0d", illegal_op, retire_cnt, m_cnt); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty got v=%b want 0", out_valid); end
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 600; i++) begin
            op = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            issue(op, $urandom, ($urandom % 4 == 0) ? 32'($urandom % 40) : $urandom,
                  12'($urandom), 1'($urandom), 5'($urandom), ($urandom % 8 == 0));
            in_valid = ($urandom % 4 != 0);
            out_ready = ($urandom % 3 != 0);
            flush = ($urandom % 32 == 0);
            tick();
            checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, out_valid, mq.size() > 0); end
            checks++; if (in_ready !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, in_ready, mq.size() < 2); end
            if (mq.size() > 0) begin
                checks++;
                if (out_rd !== mq[0].rd || out_result !== mq[0].res || out_we !== mq[0].we) begin
                    errors++;
                    $display("FAIL rnd_record cyc %0d got rd=%0d res=%h we=%b want rd=%0d res=%h we=%b", i, out_rd, out_result, out_we, mq[0].rd, mq[0].res, mq[0].we);
                end
            end
            checks++; if (retire_cnt !== m_cnt) begin errors++; $display("FAIL rnd_retire cyc %0d got %0d want %0d", i, retire_cnt, m_cnt); end
            checks++; if (illegal_op !== m_ill) begin errors++; $display("FAIL rnd_illegal cyc %0d got %b want %b", i, illegal_op, m_ill); end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        issue(4'd0, 32'd100, 32'd23, 12'd0, 1'b0, 5'd8, 1'b0);
        tick();
        issue(4'd0, 32'd1, 32'd1, 12'd0, 1'b0, 5'd9, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd123) begin errors++; $display("FAIL areset_pre got v=%b res=%0d want 1/123", out_valid, out_result); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, out_rd, out_result, out_we, illegal_op, retire_cnt} !== 72'd0) begin errors++; $display("FAIL areset_outputs got v=%b rd=%0d res=%h we=%b ill=%b cnt=%0d want all 0", out_valid, out_rd, out_result, out_we, illegal_op, retire_cnt); end
        mq.delete(); m_cnt = '0; m_ill = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL areset_after got rdy=%b v=%b want 1/0", in_ready, out_valid); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sra();
        test_backpressure();
        test_nop_rd0();
        test_illegal_flush();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
